// File: rtl/lfsr_word_gen.sv
// lfsr_word_gen: Fibonacci LFSR that packs OUT_W fresh feedback bits into a word on a valid/ready handshake
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   en_i                     step enable (FILL only)
//   seed_valid_i, seed_i     run-time seed load; a zero seed is replaced by SEED
//   word_o, word_valid_o     random word and its valid flag
//   word_ready_i             consumer accepts the word
//   state_o                  current LFSR state
module lfsr_word_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int               OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             seed_valid_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [OUT_W-1:0] word_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic [WIDTH-1:0] state_o
);
    localparam int CW = $clog2(OUT_W + 1);

    typedef enum logic {FILL, VALID} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] word_q, word_d;
    logic             last;

    assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    assign last      = cnt_q == CW'(OUT_W - 1);

    // Seed load overrides everything, including a coinciding handshake;
    // the word in flight is dropped either way since valid falls.
    always_comb begin
        fsm_d  = fsm_q;
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        word_d = word_q;
        if (seed_valid_i) begin
            lfsr_d = (seed_i == '0) ? SEED : seed_i;
            fsm_d  = FILL;
            cnt_d  = '0;
        end else if (fsm_q == VALID) begin
            fsm_d = word_ready_i ? FILL : VALID;
        end else if (en_i) begin
            lfsr_d = lfsr_step;
            cnt_d  = last ? '0 : cnt_q + CW'(1);
            fsm_d  = last ? VALID : FILL;
            word_d = last ? lfsr_step[OUT_W-1:0] : word_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q  <= FILL;
            lfsr_q <= SEED;
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = fsm_q == VALID;
    assign state_o      = lfsr_q;
endmodule

// File: tb/tb_lfsr_word_gen.sv
// tb_lfsr_word_gen: directed vector table, corner sequences and a randomized model comparison for lfsr_word_gen
module tb_lfsr_word_gen;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        seed_valid_i = 1'b0;
    logic [15:0] seed_i = '0;
    logic        word_ready_i = 1'b0;
    logic [7:0]  word_o;
    logic        word_valid_o;
    logic [15:0] state_o;

    lfsr_word_gen dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .en_i(en_i),
        .seed_valid_i(seed_valid_i),
        .seed_i(seed_i),
        .word_o(word_o),
        .word_valid_o(word_valid_o),
        .word_ready_i(word_ready_i),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          en, rdy, sv;
        logic [15:0] seed;
        bit          ev, cw;
        logic [7:0]  ew;
        bit          cs;
        logic [15:0] es;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit en, bit rdy, bit sv, logic [15:0] seed, bit ev, bit cw,
                                logic [7:0] ew, bit cs, logic [15:0] es);
        tbl.push_back('{en, rdy, sv, seed, ev, cw, ew, cs, es});
    endfunction

    // Reference model: whole-word arithmetic on the state, parity by popcount,
    // feedback bits gathered into an accumulator with a bit counter.
    logic [15:0] m_state;
    logic [7:0]  m_acc, m_word;
    bit          m_valid;
    int          m_n;

    task automatic model_reset();
        m_state = SEED;
        m_acc   = '0;
        m_word  = '0;
        m_valid = 0;
        m_n     = 0;
    endtask

    task automatic model_clock();
        bit fb;
        if (seed_valid_i) begin
            m_state = (seed_i == 0) ? SEED : seed_i;
            m_valid = 0;
            m_n     = 0;
            m_acc   = '0;
        end else if (m_valid) begin
            if (word_ready_i) m_valid = 0;
        end else if (en_i) begin
            fb      = ($countones(m_state & TAPS) % 2) == 1;
            m_state = 16'((32'(m_state) * 2 + 32'(fb)) % 65536);
            m_acc   = 8'((32'(m_acc) * 2 + 32'(fb)) % 256);
            m_n++;
            if (m_n == 8) begin
                m_word  = m_acc;
                m_valid = 1;
                m_n     = 0;
            end
        end
    endtask

    logic [15:0] fill_st [8];

    initial begin
        int steps, cyc;
        bit zero_seen;
        logic [15:0] prev;

        // States after each of the first eight steps from SEED with the
        // left-shift feedback {s[14:0], ^(s & 16'hB400)}.
        fill_st = '{16'h59C3, 16'hB387, 16'h670F, 16'hCE1E,
                    16'h9C3C, 16'h3879, 16'h70F2, 16'hE1E4};

        for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 0, 1, 8'h00, 1, fill_st[i]);
        add(1, 0, 0, 0, 1, 1, 8'hE4, 1, 16'hE1E4);
        for (int i = 0; i < 20; i++) add(i[0], 0, 0, 0, 1, 1, 8'hE4, 1, 16'hE1E4);
        add(1, 1, 0, 0, 0, 0, 8'h00, 1, 16'hE1E4);
        add(1, 0, 1, 16'h0000, 0, 0, 8'h00, 1, SEED);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 8'h00, 1, fill_st[i]);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 8'h00, 1, fill_st[2]);
        for (int i = 3; i < 7; i++) add(1, 0, 0, 0, 0, 0, 8'h00, 1, fill_st[i]);
        add(1, 0, 0, 0, 1, 1, 8'hE4, 1, 16'hE1E4);
        add(0, 1, 1, 16'h1234, 0, 0, 8'h00, 1, 16'h1234);

        @(negedge clk_i);
        @(negedge clk_i);
        chk("reset_state", 32'(state_o), 32'(SEED));
        chk("reset_valid", 32'(word_valid_o), 0);
        chk("reset_word", 32'(word_o), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            en_i = tbl[i].en;
            word_ready_i = tbl[i].rdy;
            seed_valid_i = tbl[i].sv;
            seed_i = tbl[i].seed;
            rst_ni = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            chk($sformatf("vec%0d_valid", i), 32'(word_valid_o), 32'(tbl[i].ev));
            if (tbl[i].cw) chk($sformatf("vec%0d_word", i), 32'(word_o), 32'(tbl[i].ew));
            if (tbl[i].cs) chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(tbl[i].es));
        end

        en_i = 1'b1;
        seed_valid_i = 1'b0;
        word_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("midfill_state_not_seed", 32'(state_o == SEED), 0);
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        chk("async_rst_state", 32'(state_o), 32'(SEED));
        chk("async_rst_valid", 32'(word_valid_o), 0);
        chk("async_rst_word", 32'(word_o), 0);
        @(negedge clk_i);
        chk("rst_held_state", 32'(state_o), 32'(SEED));

        word_ready_i = 1'b1;
        rst_ni = 1'b1;
        steps = 0;
        zero_seen = 0;
        prev = SEED;
        for (cyc = 0; cyc < 80000; cyc++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (state_o != prev) steps++;
            if (state_o == 0) zero_seen = 1;
            prev = state_o;
            if (state_o == SEED && steps > 0) break;
        end
        chk("period_steps", 32'(steps), 65535);
        chk("period_no_zero", 32'(zero_seen), 0);

        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            en_i = $urandom_range(0, 3) != 0;
            word_ready_i = $urandom_range(0, 1) == 1;
            seed_valid_i = $urandom_range(0, 39) == 0;
            seed_i = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            @(posedge clk_i);
            model_clock();
            @(negedge clk_i);
            chk($sformatf("rnd%0d_valid", i), 32'(word_valid_o), 32'(m_valid));
            chk($sformatf("rnd%0d_state", i), 32'(state_o), 32'(m_state));
            if (m_valid) chk($sformatf("rnd%0d_word", i), 32'(word_o), 32'(m_word));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
